// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the decoupled instruction-fetch front end.
package fetch_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int FQ_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: ring buffer of fetch entries, allocated at request accept and filled in order.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_instr,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);
  fq_entry_t ent [DEPTH];
  logic [PW-1:0] head_ptr, alloc_ptr, fill_ptr;
  assign head = ent[head_ptr];
  // fill_ptr always sits between head and alloc, so the three writes never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      ent <= '{default: '0};
      head_ptr <= '0;
      alloc_ptr <= '0;
      fill_ptr <= '0;
      count <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        ent[alloc_ptr] <= '{pc: alloc_pc, instr: 32'h0, filled: 1'b0};
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        ent[fill_ptr].instr <= fill_instr;
        ent[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (pop) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled fetch stage with in-order IM requests, stale-response dropping on redirect.
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall/perf_flush counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FQ_DEPTH = FQ_DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ready,
  input  logic              im_rvalid,
  input  logic [31:0]       im_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  input  logic              out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [15:0]       perf_flush
`endif
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  logic [31:0] pc_q;
  logic [CW-1:0] drop_cnt, count, unfilled;
  fq_entry_t head;
  logic accept, fill, drop, pop, rv_dec;
  assign im_req = !rst && !redirect_valid && (({1'b0, count} + {1'b0, drop_cnt}) < (CW+1)'(FQ_DEPTH));
  assign im_addr = pc_q[ADDR_W+1:2];
  assign accept = im_req && im_ready;
  assign drop = im_rvalid && drop_cnt != '0;
  assign fill = im_rvalid && drop_cnt == '0 && unfilled != '0 && !redirect_valid;
  assign rv_dec = im_rvalid && (drop_cnt != '0 || unfilled != '0);
  assign out_valid = head.filled && count != '0 && !redirect_valid;
  assign pop = out_valid && out_ready;
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .alloc(accept),
    .alloc_pc(pc_q),
    .fill(fill),
    .fill_instr(im_rdata),
    .pop(pop),
    .head(head),
    .count(count),
    .unfilled(unfilled)
  );
  // on redirect every unfilled entry becomes a response to discard, less one arriving right now
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~32'h3;
      drop_cnt <= drop_cnt + unfilled - CW'(rv_dec);
    end else begin
      if (accept) pc_q <= pc_q + 32'd4;
      if (drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall <= perf_stall + 32'(im_req && !im_ready);
      perf_flush <= perf_flush + 16'(redirect_valid);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random bench with an IM latency model and an in-order pc/instr scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam int ADDR_W = 14;
  logic clk = 0, rst = 1;
  logic im_req, im_ready = 1, im_rvalid = 0, redirect_valid = 0, out_valid, out_ready = 1;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_rdata = 0, redirect_pc = 0, out_pc, out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [15:0] perf_flush;
`endif
  fetch_unit dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { logic [ADDR_W-1:0] a; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  req_t pend[$];
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, lat = 1, accepts = 0, stalls = 0;
  logic [31:0] ref_pc = 0, hpc = 0, hin = 0;
  logic hold = 0;
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return ({18'h0, a} * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    assert (out_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s timeout observed=%b expected=1", tag, out_valid);
    end
  endtask
  always @(posedge clk) cyc++;
  // in-order memory: one response per accepted request, lat cycles after accept
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      im_rvalid = 0;
      im_rdata = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      im_rvalid = 1;
      im_rdata = mem_word(pend[0].a);
      void'(pend.pop_front());
    end else begin
      im_rvalid = 0;
      im_rdata = 0;
    end
  end
  // monitor just before each rising edge: what the DUT is about to do this edge
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (rst) begin
      sb.delete();
      ref_pc = RESET_PC_DEF;
      stalls = 0;
      hold = 0;
    end else if (redirect_valid) begin
      sb.delete();
      ref_pc = redirect_pc & ~32'h3;
      hold = 0;
    end else begin
      if (hold && out_valid) begin
        chk("hold_pc", out_pc, hpc);
        chk("hold_instr", out_instr, hin);
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=pop expected=no_pop pc=%h", out_pc);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_pc", out_pc, e.pc);
          chk("sb_instr", out_instr, e.instr);
        end
      end
      if (im_req && im_ready) begin
        chk("sb_addr", 32'(im_addr), 32'(ref_pc[ADDR_W+1:2]));
        sb.push_back('{ref_pc, mem_word(ref_pc[ADDR_W+1:2])});
        pend.push_back('{im_addr, cyc + 1 + lat});
        ref_pc += 4;
        accepts++;
      end
      if (im_req && !im_ready) stalls++;
      hold = out_valid && !out_ready;
      hpc = out_pc;
      hin = out_instr;
    end
  end
  initial begin
    int a0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_im_req", 32'(im_req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_im_addr", 32'(im_addr), 0);
    @(negedge clk) rst = 0;
    #1 chk("first_req", 32'(im_req), 1);
    @(negedge clk); #1;
    chk("seq_addr1", 32'(im_addr), 1);
    chk("seq_nvalid", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("seq_valid", 32'(out_valid), 1);
    chk("seq_pc0", out_pc, 32'h0);
    chk("seq_addr2", 32'(im_addr), 2);
    @(negedge clk); #1 chk("seq_pc4", out_pc, 32'h4);
    @(negedge clk); #1 chk("seq_pc8", out_pc, 32'h8);
    // backpressure: queue fills with 4 requests then issue stops
    @(negedge clk) rst = 1;
    out_ready = 0;
    @(negedge clk) rst = 0;
    a0 = accepts;
    repeat (6) begin
      @(negedge clk); #1;
      chk("stall_head_pc", out_pc, 0);
    end
    chk("stall_accepts", 32'(accepts - a0), 4);
    chk("stall_no_req", 32'(im_req), 0);
    out_ready = 1;
    #1 chk("no_req_before_pop", 32'(im_req), 0);
    @(negedge clk); #1 chk("req_after_pop", 32'(im_req), 1);
    // 3-cycle memory, redirect with requests in flight
    lat = 3;
    repeat (8) @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 32'h102;
    #1;
    chk("redir_no_req", 32'(im_req), 0);
    chk("redir_no_valid", 32'(out_valid), 0);
    @(negedge clk) redirect_valid = 0;
    #1;
    chk("redir_req", 32'(im_req), 1);
    chk("redir_addr", 32'(im_addr), 32'h40);
    wait_valid("redir_wait");
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_instr", out_instr, mem_word(14'h40));
    // 1-cycle memory redirect latency
    lat = 1;
    repeat (8) @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 32'h200;
    @(negedge clk) redirect_valid = 0;
    #1 chk("lat1_addr", 32'(im_addr), 32'h80);
    @(negedge clk);
    @(negedge clk); #1;
    chk("lat1_valid", 32'(out_valid), 1);
    chk("lat1_pc", out_pc, 32'h200);
    // response coincident with redirect, two outstanding
    @(negedge clk) rst = 1;
    im_ready = 0;
    lat = 2;
    @(negedge clk) rst = 0;
    @(negedge clk) im_ready = 1;
    @(negedge clk);
    @(negedge clk) redirect_valid = 1;
    redirect_pc = 32'h100;
    @(negedge clk) redirect_valid = 0;
    wait_valid("coin_wait");
    chk("coin_pc", out_pc, 32'h100);
    chk("coin_instr", out_instr, mem_word(14'h40));
    // random im_ready/out_ready/latency/redirects
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      im_ready = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      lat = $urandom_range(1, 3);
      redirect_valid = $urandom_range(0, 24) == 0;
      redirect_pc = $urandom_range(0, 32'hFFFF);
    end
    @(negedge clk) redirect_valid = 0;
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall, 32'(stalls));
`endif
    // async reset with two entries queued
    @(negedge clk) rst = 1;
    out_ready = 0;
    im_ready = 1;
    lat = 1;
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_addr", 32'(im_addr), 0);
    chk("async_req", 32'(im_req), 0);
    @(negedge clk);
    @(negedge clk) rst = 0;
    out_ready = 1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("restart_valid", 32'(out_valid), 1);
    chk("restart_pc", out_pc, 0);
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
